aes_spi_slave: RTL

- SPI slave (mode 0, MSB first) at the far end of the AES SPI link.
- Per frame it receives a 128-bit plaintext block followed by a 128/192/256-bit key, and presents both to the AES core.
- In the same full-duplex frame it shifts the previously loaded 128-bit result back on MISO.
- All SPI inputs are oversampled and synchronised into the single system clock domain.

---
 rtl/aes_spi_slave.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aes_spi_slave.sv
`timescale 1ns/1ps
// SPI mode-0 slave for the AES link: receives plaintext + key, returns the previous result on MISO.
// Optional frame checking is enabled by defining AES_SPI_SLAVE_FRAME_CHECK_EN.
module aes_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [1:0]   size,
    output logic [127:0] pt_out,
    output logic [255:0] key_out,
    output logic         rx_valid,
    input  logic [127:0] tx_data,
    input  logic         tx_load,
    output logic         tx_busy,
    output logic         frame_err
);

    typedef enum logic [1:0] {IDLE, RECV_PT, RECV_KEY, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d, mosi_d;
    logic [8:0]             cnt;
    logic [1:0]             size_r;
    logic [127:0]           pt_sr;
    logic [255:0]           key_sr;
    logic [127:0]           tx_buf;
    logic [7:0]             tx_ptr;
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
    logic                   extra_bits;
`endif

    function automatic logic [8:0] key_last(input logic [1:0] sz);
        case (sz)
            2'b01:   key_last = 9'd191;
            2'b10:   key_last = 9'd255;
            default: key_last = 9'd127;
        endcase
    endfunction

    // cs_n synchroniser resets high so release of reset never looks like a frame start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            mosi_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
        end
    end

    wire sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    wire sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
    wire cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_d;
    wire cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_d;

    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            size_r   <= '0;
            pt_sr    <= '0;
            key_sr   <= '0;
            tx_buf   <= '0;
            tx_ptr   <= '0;
            miso     <= 1'b0;
            pt_out   <= '0;
            key_out  <= '0;
            rx_valid <= 1'b0;
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
            frame_err  <= 1'b0;
            extra_bits <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
            if (state == IDLE) begin
                miso <= 1'b0;
                if (tx_load)
                    tx_buf <= tx_data;
                if (cs_fall) begin
                    state  <= RECV_PT;
                    size_r <= size;
                    cnt    <= '0;
                    pt_sr  <= '0;
                    key_sr <= '0;
                    tx_ptr <= '0;
                    // a load coinciding with the frame start is what gets sent
                    miso   <= tx_load ? tx_data[127] : tx_buf[127];
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
                    extra_bits <= 1'b0;
`endif
                end
            end else if (cs_rise) begin
                state <= IDLE;
                miso  <= 1'b0;
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
                frame_err <= (state != DONE) || extra_bits;
`endif
            end else begin
                if (sclk_fall) begin
                    if (tx_ptr < 8'd127) begin
                        miso   <= tx_buf[7'd126 - tx_ptr[6:0]];
                        tx_ptr <= tx_ptr + 8'd1;
                    end else begin
                        miso <= 1'b0;
                    end
                end
                if (sclk_rise) begin
                    case (state)
                        RECV_PT: begin
                            pt_sr <= {pt_sr[126:0], mosi_d};
                            if (cnt == 9'd127) begin
                                cnt   <= '0;
                                state <= RECV_KEY;
                            end else begin
                                cnt <= cnt + 9'd1;
                            end
                        end
                        RECV_KEY: begin
                            key_sr <= {key_sr[254:0], mosi_d};
                            cnt    <= cnt + 9'd1;
                            if (cnt == key_last(size_r)) begin
                                pt_out   <= pt_sr;
                                key_out  <= {key_sr[254:0], mosi_d};
                                rx_valid <= 1'b1;
                                state    <= DONE;
                            end
                        end
                        DONE: begin
`ifdef AES_SPI_SLAVE_FRAME_CHECK_EN
                            extra_bits <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifndef AES_SPI_SLAVE_FRAME_CHECK_EN
    assign frame_err = 1'b0;
`endif

endmodule
